// File: rtl/tile_write_scheduler_pkg.sv
// Shared definitions for the ping-pong tile frame buffer: geometry, scheduler
// states and the pixel-to-tile address helper used by the buffer controller too.
package tile_fb_pkg;

  localparam int TILES  = 320;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] TILE_LIMIT = ADDR_W'(TILES);
  localparam logic [ADDR_W-1:0] LAST_TILE  = ADDR_W'(TILES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, ARB} schedState_t;

  // 40x24-pixel tiles, 16 tiles per row.
  function automatic logic [ADDR_W-1:0] tileAddr(input logic [9:0] h, input logic [9:0] v);
    return (h / 10'd40) + ((v / 10'd24) * 10'd16);
  endfunction

  function automatic logic tileInRange(input logic [ADDR_W-1:0] addr);
    return addr < TILE_LIMIT;
  endfunction

endpackage

// File: rtl/tile_write_scheduler_if.sv
// Control, requester handshake and buffer write bus of the tile write scheduler.
interface tile_write_scheduler_if;
  import tile_fb_pkg::*;

  logic              frame_start;
  logic              clear_en;
  logic [DATA_W-1:0] bg_color;
  logic              req_a;
  logic              req_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              ack_a;
  logic              ack_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_ready;
  logic              overrun;
  logic              addr_err;

  modport master (
    output frame_start, clear_en, bg_color, req_a, req_b, addr_a, addr_b, data_a, data_b,
    input  ack_a, ack_b, wr_en, wr_addr, wr_data, frame_ready, overrun, addr_err
  );

  modport slave (
    input  frame_start, clear_en, bg_color, req_a, req_b, addr_a, addr_b, data_a, data_b,
    output ack_a, ack_b, wr_en, wr_addr, wr_data, frame_ready, overrun, addr_err
  );

endinterface

// File: rtl/tile_write_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant over an eligibility mask,
// pointer remembers the last winner and moves only when a grant is issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic lastB;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (eligible == 2'b11) grant = lastB ? 2'b01 : 2'b10;
      else                   grant = eligible;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lastB <= 1'b1;
    end else if (grant != 2'b00) begin
      lastB <= grant[1];
    end
  end

endmodule

// File: rtl/tile_write_scheduler.sv
// Owns the frame-buffer write port: optionally clears the fresh buffer after
// each swap, then serves two tile-drawing requesters round-robin.
module tile_write_scheduler
  import tile_fb_pkg::*;
(
  input logic clk,
  input logic reset,
  tile_write_scheduler_if.slave bus
);

  schedState_t       state;
  logic [ADDR_W-1:0] clearCnt;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic              arbEnable;
  logic [ADDR_W-1:0] grantAddr;
  logic [DATA_W-1:0] grantData;

  // A requester whose ack is showing this cycle is still holding the consumed request.
  assign eligible  = {bus.req_b & ~bus.ack_b, bus.req_a & ~bus.ack_a};
  assign arbEnable = (state == ARB) && !bus.frame_start;
  assign grantAddr = grant[1] ? bus.addr_b : bus.addr_a;
  assign grantData = grant[1] ? bus.data_b : bus.data_a;

  rr_arbiter2 arbiter (
    .clk      (clk),
    .reset    (reset),
    .enable   (arbEnable),
    .eligible (eligible),
    .grant    (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      clearCnt        <= '0;
      bus.ack_a       <= 1'b0;
      bus.ack_b       <= 1'b0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.frame_ready <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.addr_err    <= 1'b0;
    end else begin
      bus.ack_a <= 1'b0;
      bus.ack_b <= 1'b0;
      bus.wr_en <= 1'b0;
      if (bus.frame_start) begin
        if (state == CLEAR) bus.overrun <= 1'b1;
        // A swap always (re)starts the clear with the address-0 write on this same edge.
        if (state == CLEAR || bus.clear_en) begin
          state           <= CLEAR;
          bus.frame_ready <= 1'b0;
          clearCnt        <= ADDR_W'(1);
          bus.wr_en       <= 1'b1;
          bus.wr_addr     <= '0;
          bus.wr_data     <= bus.bg_color;
        end else begin
          state           <= ARB;
          bus.frame_ready <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
          end
          CLEAR: begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= clearCnt;
            bus.wr_data <= bus.bg_color;
            if (clearCnt == LAST_TILE) begin
              state           <= ARB;
              bus.frame_ready <= 1'b1;
              clearCnt        <= '0;
            end else begin
              clearCnt <= clearCnt + ADDR_W'(1);
            end
          end
          ARB: begin
            if (grant != 2'b00) begin
              bus.ack_a   <= grant[0];
              bus.ack_b   <= grant[1];
              bus.wr_addr <= grantAddr;
              bus.wr_data <= grantData;
              bus.wr_en   <= tileInRange(grantAddr);
              if (!tileInRange(grantAddr)) bus.addr_err <= 1'b1;
            end
          end
          default: begin
            state           <= IDLE;
            bus.frame_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tile_write_scheduler.sv
// Directed and randomized bench for tile_write_scheduler, checked every cycle
// against a transaction-level model of the clear/serve behaviour.
module tb_tile_write_scheduler;
  import tile_fb_pkg::*;

  localparam int MODE_QUIET = 0;
  localparam int MODE_WIPE  = 1;
  localparam int MODE_SERVE = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset;

  tile_write_scheduler_if bus ();

  tile_write_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  txn_t qA[$];
  txn_t qB[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycle       = 0;
  int   writeCount  = 0;
  bit   ackLog[$];
  int   ackCycles[$];
  bit   randomBg    = 1'b0;

  int                mode;
  int                wipeAddr;
  bit                lastWasB;
  bit                prevAckA, prevAckB;
  bit                stickyOverrun, stickyAddrErr;
  bit                expAckA, expAckB, expWrEn, expReady, expZeroBus;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expData;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic txn_t randomTxn();
    txn_t t;
    t.addr = ADDR_W'($urandom_range(0, 399));
    t.data = DATA_W'($urandom);
    return t;
  endfunction

  // Work out what should become visible after the coming edge.
  task automatic predict();
    bit serving, eligA, eligB, pickA;
    txn_t t;
    expAckA = 1'b0;
    expAckB = 1'b0;
    expWrEn = 1'b0;
    expZeroBus = 1'b0;
    if (reset) begin
      mode = MODE_QUIET;
      wipeAddr = 0;
      lastWasB = 1'b1;
      stickyOverrun = 1'b0;
      stickyAddrErr = 1'b0;
      expReady = 1'b0;
      prevAckA = 1'b0;
      prevAckB = 1'b0;
      expZeroBus = 1'b1;
      return;
    end
    serving = (mode == MODE_SERVE) && !bus.frame_start;
    if (bus.frame_start) begin
      if (mode == MODE_WIPE) stickyOverrun = 1'b1;
      if (mode == MODE_WIPE || bus.clear_en) begin
        mode = MODE_WIPE;
        wipeAddr = 0;
      end else begin
        mode = MODE_SERVE;
      end
    end
    if (mode == MODE_WIPE) begin
      expWrEn = 1'b1;
      expAddr = ADDR_W'(wipeAddr);
      expData = bus.bg_color;
      wipeAddr++;
      if (wipeAddr == TILES) mode = MODE_SERVE;
    end else if (serving) begin
      eligA = (qA.size() != 0) && !prevAckA;
      eligB = (qB.size() != 0) && !prevAckB;
      if (eligA || eligB) begin
        pickA = eligA && (!eligB || lastWasB);
        lastWasB = !pickA;
        t = pickA ? qA[0] : qB[0];
        expAckA = pickA;
        expAckB = !pickA;
        expAddr = t.addr;
        expData = t.data;
        expWrEn = (int'(t.addr) < TILES);
        if (!expWrEn) stickyAddrErr = 1'b1;
      end
    end
    expReady = (mode == MODE_SERVE);
    prevAckA = expAckA;
    prevAckB = expAckB;
  endtask

  task automatic applyStimulus();
    bus.frame_start = 1'b0;
    if (randomBg) bus.bg_color = DATA_W'($urandom);
    bus.req_a = (qA.size() != 0);
    if (qA.size() != 0) begin
      bus.addr_a = qA[0].addr;
      bus.data_a = qA[0].data;
    end
    bus.req_b = (qB.size() != 0);
    if (qB.size() != 0) begin
      bus.addr_b = qB[0].addr;
      bus.data_b = qB[0].data;
    end
  endtask

  task automatic runCycle();
    predict();
    @(posedge clk);
    cycle++;
    #1;
    if (bus.wr_en === 1'b1) writeCount++;
    if (bus.ack_a === 1'b1) begin ackLog.push_back(1'b1); ackCycles.push_back(cycle); end
    if (bus.ack_b === 1'b1) begin ackLog.push_back(1'b0); ackCycles.push_back(cycle); end
    checkOutput("ack_a", bus.ack_a, expAckA);
    checkOutput("ack_b", bus.ack_b, expAckB);
    checkOutput("wr_en", bus.wr_en, expWrEn);
    checkOutput("frame_ready", bus.frame_ready, expReady);
    checkOutput("overrun", bus.overrun, stickyOverrun);
    checkOutput("addr_err", bus.addr_err, stickyAddrErr);
    if (expWrEn) begin
      checkOutput("wr_addr", bus.wr_addr, expAddr);
      checkOutput("wr_data", bus.wr_data, expData);
    end
    if (expZeroBus) begin
      checkOutput("reset_wr_addr", bus.wr_addr, 0);
      checkOutput("reset_wr_data", bus.wr_data, 0);
    end
    if (expAckA) qA.delete(0);
    if (expAckB) qB.delete(0);
    applyStimulus();
  endtask

  task automatic drain(input int maxCycles);
    int n = 0;
    while ((qA.size() != 0 || qB.size() != 0) && n < maxCycles) begin
      runCycle();
      n++;
    end
    runCycle();
    runCycle();
    checkOutput("drain_pending", qA.size() + qB.size(), 0);
  endtask

  initial begin
    int fsEdge;
    int alternations;
    txn_t t;

    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.clear_en = 1'b0;
    bus.bg_color = '0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.addr_a = '0;
    bus.addr_b = '0;
    bus.data_a = '0;
    bus.data_b = '0;
    repeat (3) runCycle();
    reset = 1'b0;
    repeat (2) runCycle();

    // Reset, then a full clear to 0x1C.
    bus.clear_en = 1'b1;
    bus.bg_color = 8'h1C;
    bus.frame_start = 1'b1;
    writeCount = 0;
    ackLog.delete();
    repeat (TILES) runCycle();
    checkOutput("clear_writes", writeCount, TILES);
    checkOutput("clear_acks", ackLog.size(), 0);
    checkOutput("ready_after_clear", bus.frame_ready, 1);
    runCycle();

    // Contested arbitration, both held continuously.
    for (int i = 0; i < 6; i++) begin
      qA.push_back('{addr: ADDR_W'(5), data: 8'hA0});
      qB.push_back('{addr: ADDR_W'(7), data: 8'hB0});
    end
    applyStimulus();
    ackLog.delete();
    ackCycles.delete();
    drain(40);
    checkOutput("contested_acks", ackLog.size(), 12);
    if (ackLog.size() == 12) begin
      checkOutput("contested_first_a", ackLog[0], 1);
      alternations = 0;
      for (int i = 1; i < 12; i++) if (ackLog[i] != ackLog[i-1]) alternations++;
      checkOutput("contested_alternation", alternations, 11);
      checkOutput("contested_span", ackCycles[11] - ackCycles[0], 11);
    end

    // Single requester re-asserting immediately.
    for (int i = 0; i < 5; i++) begin
      t = randomTxn();
      t.addr = ADDR_W'($urandom_range(0, TILES - 1));
      qA.push_back(t);
    end
    applyStimulus();
    ackCycles.delete();
    drain(30);
    checkOutput("single_acks", ackCycles.size(), 5);
    for (int i = 1; i < ackCycles.size(); i++)
      checkOutput("single_gap", ackCycles[i] - ackCycles[i-1], 2);

    // Swap while B is pending at address 12.
    qB.push_back('{addr: ADDR_W'(12), data: DATA_W'($urandom)});
    applyStimulus();
    bus.clear_en = 1'b1;
    bus.frame_start = 1'b1;
    fsEdge = cycle + 1;
    ackCycles.delete();
    drain(TILES + 20);
    checkOutput("swap_ack_count", ackCycles.size(), 1);
    if (ackCycles.size() != 0) checkOutput("swap_latency", ackCycles[0] - fsEdge, TILES);

    // Second frame_start 100 cycles into a clear, bg changing every cycle.
    randomBg = 1'b1;
    bus.frame_start = 1'b1;
    repeat (100) runCycle();
    bus.frame_start = 1'b1;
    writeCount = 0;
    repeat (TILES) runCycle();
    checkOutput("overrun_set", bus.overrun, 1);
    checkOutput("overrun_rewrites", writeCount, TILES);
    checkOutput("overrun_ready", bus.frame_ready, 1);
    randomBg = 1'b0;

    // Out-of-range address on the no-clear path.
    bus.clear_en = 1'b0;
    bus.frame_start = 1'b1;
    runCycle();
    qA.push_back('{addr: ADDR_W'(400), data: 8'h5A});
    applyStimulus();
    runCycle();
    checkOutput("bad_ack_a", bus.ack_a, 1);
    checkOutput("bad_wr_en", bus.wr_en, 0);
    checkOutput("bad_addr_err", bus.addr_err, 1);

    // Randomized traffic with occasional swaps and clears.
    randomBg = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (qA.size() < 3 && $urandom_range(0, 3) == 0) qA.push_back(randomTxn());
      if (qB.size() < 3 && $urandom_range(0, 3) == 0) qB.push_back(randomTxn());
      applyStimulus();
      if ($urandom_range(0, 59) == 0) begin
        bus.clear_en = ($urandom_range(0, 3) == 0);
        bus.frame_start = 1'b1;
      end
      runCycle();
    end
    checkOutput("addr_err_sticky", bus.addr_err, 1);

    // Reset in the middle of a clear aborts everything.
    bus.clear_en = 1'b1;
    bus.frame_start = 1'b1;
    repeat (50) runCycle();
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    checkOutput("reset_addr_err", bus.addr_err, 0);
    checkOutput("reset_overrun", bus.overrun, 0);
    repeat (3) runCycle();
    bus.clear_en = 1'b0;
    bus.frame_start = 1'b1;
    drain(40);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
